// File: rtl/data_memory_unit.sv
// Word-addressed data RAM for CPU LW/SW with valid/ready request/response and WAIT_CYCLES wait states.
// Latency: accept at E0, resp_valid after E0+WAIT_CYCLES+1; response held until resp_ready.
// Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned addresses with resp_err.
module data_memory_unit #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic               write_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic               bad_align_q;
  logic               resp_valid_q;
  logic               resp_err_q;
  logic [31:0]        resp_rdata_q;

  logic [31:0]        mem [DEPTH];

  logic               req_misalign;
  logic               in_range;
  logic               access_ok;
  logic               access_now;
  logic               mem_we;
  logic [MEM_AW-1:0]  mem_idx;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_misalign = |req_addr[1:0];
`else
  // Byte offset is deliberately dropped: accesses go to the containing word.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign req_misalign    = 1'b0;
`endif

  assign in_range   = 32'(idx_q) < 32'(DEPTH);
  assign access_ok  = in_range && !bad_align_q;
  assign access_now = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we     = access_now && access_ok && write_q;
  assign mem_idx    = idx_q[MEM_AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      bad_align_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            idx_q       <= req_addr[ADDR_W-1:2];
            wdata_q     <= req_wdata;
            bad_align_q <= req_misalign;
            cnt_q       <= 4'(WAIT_CYCLES);
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Read sees the pre-edge RAM word; the store lands on this same edge.
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= !access_ok;
            resp_rdata_q <= (access_ok && !write_q) ? mem[mem_idx] : 32'd0;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: default instance plus a DEPTH=128, WAIT_CYCLES=0 instance.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [9:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
  );

  data_memory_unit #(.ADDR_W(10), .DEPTH(128), .WAIT_CYCLES(0)) u_dut_small (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response, then consume it.
  task automatic xact(input int u, input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat);
    req_valid[u] = 1'b1;
    req_write[u] = wr;
    req_addr[u]  = addr;
    req_wdata[u] = wd;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    req_addr[u]  = ~addr;
    req_wdata[u] = ~wd;
    lat = 0;
    while (!resp_valid[u] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = resp_rdata[u];
    err = resp_err[u];
    resp_ready[u] = 1'b1;
    @(posedge clk); #1;
    resp_ready[u] = 1'b0;
  endtask

  task automatic run(input int u, input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat, input string tag);
    logic [31:0] rd;
    logic        err;
    int          lat;
    xact(u, wr, addr, wd, rd, err, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [31:0] exp_w8;
    logic        exp_err22;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_write[i]  = 1'b0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
      resp_ready[i] = 1'b0;
    end
    #3;
    check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_busy",       32'(busy[0]),       32'd0);
    check("rst_req_ready",  32'(req_ready[0]),  32'd1);
    check("rst_rdata",      resp_rdata[0],      32'd0);
    check("rst_err",        32'(resp_err[0]),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load, latency WAIT_CYCLES+1
    run(0, 1'b1, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0, 3, "sw010");
    run(0, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, "lw010");

    // Top word of a full-depth RAM, then out of range on the small instance
    run(0, 1'b1, 10'h3FC, 32'hA5A50001, 32'h0,        1'b0, 3, "sw3fc");
    run(0, 1'b0, 10'h3FC, 32'h0,        32'hA5A50001, 1'b0, 3, "lw3fc");
    run(1, 1'b1, 10'h1FC, 32'h11111111, 32'h0,        1'b0, 1, "b_sw1fc");
    run(1, 1'b1, 10'h3FC, 32'h22222222, 32'h0,        1'b1, 1, "b_sw3fc");
    run(1, 1'b0, 10'h1FC, 32'h0,        32'h11111111, 1'b0, 1, "b_lw1fc");
    run(1, 1'b0, 10'h3FC, 32'h0,        32'h0,        1'b1, 1, "b_lw3fc");

    // Backpressure: response held, competing request ignored
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 10'h010;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    seen = 0;
    while (!resp_valid[0] && seen < 40) begin
      @(posedge clk); #1;
      seen++;
    end
    check("bp_lat", 32'(seen), 32'd3);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 10'h010; req_wdata[0] = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_%0d", c), 32'(resp_valid[0]), 32'd1);
      check($sformatf("bp_rdata_%0d", c), resp_rdata[0],      32'hDEADBEEF);
      check($sformatf("bp_ready_%0d", c), 32'(req_ready[0]),  32'd0);
      check($sformatf("bp_busy_%0d", c),  32'(busy[0]),       32'd1);
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    check("bp_rel_valid", 32'(resp_valid[0]), 32'd0);
    check("bp_rel_ready", 32'(req_ready[0]),  32'd1);
    check("bp_rel_busy",  32'(busy[0]),       32'd0);
    check("bp_rel_rdata", resp_rdata[0],      32'hDEADBEEF);
    run(0, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, "bp_lw010");

    // Misaligned store to word 8
`ifdef DMEM_ALIGN_CHECK_EN
    exp_w8    = 32'hCAFE0000;
    exp_err22 = 1'b1;
`else
    exp_w8    = 32'h00000001;
    exp_err22 = 1'b0;
`endif
    run(0, 1'b1, 10'h020, 32'hCAFE0000, 32'h0,  1'b0,      3, "sw020");
    run(0, 1'b1, 10'h022, 32'h00000001, 32'h0,  exp_err22, 3, "sw022");
    run(0, 1'b0, 10'h020, 32'h0,        exp_w8, 1'b0,      3, "lw020");

    // Reset during WAIT discards the pending store
    run(0, 1'b1, 10'h040, 32'h12345678, 32'h0, 1'b0, 3, "sw040");
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 10'h040; req_wdata[0] = 32'h87654321;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("mid_rst_busy",       32'(busy[0]),       32'd0);
    check("mid_rst_req_ready",  32'(req_ready[0]),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid[0]) seen++;
    end
    check("mid_no_resp", 32'(seen), 32'd0);
    run(0, 1'b0, 10'h040, 32'h0, 32'h12345678, 1'b0, 3, "lw040");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
